rec_buf_rot_nbank: RTL and testbench
====================================

Name: rec_buf_rot_nbank

Overview:
Generalised N-bank rotating ping-pong buffer for the reconstruction wrapper, covering mvd, mode and other per-4x4 side info.
- BANK_NUM single-port banks are handed from pipeline stage to pipeline stage by a rotate pulse.
- Every stage has a live write port and a live read port; none are tied off.
- Each entry carries a written flag, so a bank re-entering stage 0 reads as cleared.
- Read data carries an explicit valid strobe, and same-stage read/write collisions are flagged.

Parameters:
BANK_NUM, 3, number of banks and stages (2..4)
DAT_WIDTH, 23, entry width (2*MVD_WIDTH+1 for the mvd use)
ADR_WIDTH, 6, entry address width
DEPTH, 64, entries per bank (<= 2**ADR_WIDTH)
PTR_WIDTH, 2, rotate pointer width (2**PTR_WIDTH >= BANK_NUM)

Ports:
clk  input  1  clock, all state updates on rising edge
rstn  input  1  asynchronous active-low reset
rotate_i  input  1  one-cycle pulse: advance bank-to-stage mapping
wr_ena_i  input  BANK_NUM  per-stage write enable
wr_adr_i  input  BANK_NUM*ADR_WIDTH  per-stage write address, stage k in slice k
wr_dat_i  input  BANK_NUM*DAT_WIDTH  per-stage write data
rd_ena_i  input  BANK_NUM  per-stage read enable
rd_adr_i  input  BANK_NUM*ADR_WIDTH  per-stage read address
rd_dat_o  output  BANK_NUM*DAT_WIDTH  per-stage read data, registered
rd_vld_o  output  BANK_NUM  per-stage read-data-valid pulse
conflict_o  output  BANK_NUM  per-stage pulse: write dropped due to same-cycle read
rot_ptr_o  output  PTR_WIDTH  current rotate pointer

Behaviour:
- Reset (async, rstn=0):
  - rot_ptr_o=0; all written flags=0; rd_dat_o=0; rd_vld_o=0; conflict_o=0.
  - RAM array is not reset; it is masked by the written flags.
- Pointer:
  - On rotate_i, ptr <= (ptr==BANK_NUM-1) ? 0 : ptr+1.
  - rotate_i with ptr at max wraps to 0.
- Mapping: stage k accesses bank (k - ptr) mod BANK_NUM. All accesses in a cycle use the pre-edge ptr. Consequences:
  - Data written by stage k is visible to stage k+1 after one rotate.
  - With BANK_NUM=3, ptr=1: stage0->bank2, stage1->bank0, stage2->bank1.
- Write: wr_ena_i[k]=1 and rd_ena_i[k]=0 at edge t gives:
  - bank[adr] <= dat;
  - flag[bank][adr] <= 1.
- Read:
  - rd_ena_i[k]=1 at cycle t gives rd_vld_o[k]=1 for exactly cycle t+1.
  - In that cycle, rd_dat_o[k] = the bank entry if its flag=1, else 0.
  - Latency is 1.
  - rd_dat_o[k] holds its value until the next read on stage k.
  - The stage that receives the data is the stage that issued the read, even if rotate_i fires in cycle t. The stage/bank select is registered with the read.
- Same-stage collision (rd_ena_i[k] and wr_ena_i[k] both 1):
  - Read wins the single bank port; the write is discarded and its flag is unchanged.
  - conflict_o[k]=1 for cycle t+1 only.
- Cross-stage accesses always hit distinct banks and never interact.
- Rotate clear: on an edge with rotate_i=1, all flags of bank (BANK_NUM-1-ptr) mod BANK_NUM are cleared. This is the bank leaving the last stage and entering stage 0.
  - A read of that bank in the same cycle returns pre-clear content at t+1.
  - A write to that bank in the same cycle is lost: clear has priority.
- Reset mid-operation:
  - Pending rd_vld_o/conflict_o pulses are cancelled.
  - All banks read 0 after reset until rewritten.
- Addresses >= DEPTH: do not care. The bench must not drive them.

Test Plan:
1. BANK_NUM=3, ptr=0: stage0 writes adr 5=0x12345, then rotate. Stage1 reads adr 5 -> rd_vld_o[1]=1 next cycle, rd_dat_o[1]=0x12345, rot_ptr_o=1.
2. Continue from 1: rotate again, stage2 reads adr 5 -> 0x12345. Rotate a third time (ptr 2->0), stage0 reads adr 5 -> rd_dat_o[0]=0 with rd_vld_o[0]=1.
3. Same cycle: stage0 rd adr 3 and wr adr 3=0x7F. Next cycle conflict_o[0]=1; a later read of adr 3 returns 0, not 0x7F.
4. Stage2 reads adr 9 (prior value 0x55) in the same cycle as rotate_i. Next cycle rd_dat_o[2]=0x55 and rd_vld_o[2]=1. That bank then reads 0 from stage0.
5. Write all 64 addresses in stage0, then assert rstn=0 for 1 cycle mid-burst. All outputs read 0, rot_ptr_o=0, and subsequent reads return 0.
6. Parameter sweep with BANK_NUM=2 and 4, DAT_WIDTH=8: a token written in stage0 follows through every stage and clears after BANK_NUM rotates.

Source files
------------

// File: rtl/rec_buf_rot_nbank.sv
// rtl/rec_buf_rot_nbank.sv - N-bank rotating buffer with per-entry written flags
module rec_buf_rot_nbank #(
    parameter int BANK_NUM  = 3,
    parameter int DAT_WIDTH = 23,
    parameter int ADR_WIDTH = 6,
    parameter int DEPTH     = 64,
    parameter int PTR_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           rotate_i,
    input  logic [BANK_NUM-1:0]            wr_ena_i,
    input  logic [BANK_NUM*ADR_WIDTH-1:0]  wr_adr_i,
    input  logic [BANK_NUM*DAT_WIDTH-1:0]  wr_dat_i,
    input  logic [BANK_NUM-1:0]            rd_ena_i,
    input  logic [BANK_NUM*ADR_WIDTH-1:0]  rd_adr_i,
    output logic [BANK_NUM*DAT_WIDTH-1:0]  rd_dat_o,
    output logic [BANK_NUM-1:0]            rd_vld_o,
    output logic [BANK_NUM-1:0]            conflict_o,
    output logic [PTR_WIDTH-1:0]           rot_ptr_o
);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(BANK_NUM - 1);

    logic [PTR_WIDTH-1:0]          ptr_q, ptr_d, clr_bank;
    logic [PTR_WIDTH-1:0]          bank_sel [BANK_NUM];
    logic [BANK_NUM-1:0]           wr_go;
    logic [DAT_WIDTH-1:0]          mem_q    [BANK_NUM][DEPTH];
    logic [DEPTH-1:0]              flag_q   [BANK_NUM];
    logic [BANK_NUM*DAT_WIDTH-1:0] rd_dat_q;
    logic [BANK_NUM-1:0]           rd_vld_q, conflict_q;

    // Modular subtraction relies on wrap-around within PTR_WIDTH bits.
    always_comb begin
        ptr_d = ptr_q;
        if (rotate_i) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_WIDTH'(1);
        end
        clr_bank = PTR_LAST - ptr_q;
        for (int k = 0; k < BANK_NUM; k++) begin
            bank_sel[k] = (PTR_WIDTH'(k) >= ptr_q) ? PTR_WIDTH'(k) - ptr_q
                                                   : PTR_WIDTH'(k + BANK_NUM) - ptr_q;
            wr_go[k]    = wr_ena_i[k] & ~rd_ena_i[k];
        end
    end

    // Entry storage is left unreset; stale content is masked by flag_q.
    always_ff @(posedge clk) begin
        for (int k = 0; k < BANK_NUM; k++) begin
            if (wr_go[k]) begin
                mem_q[bank_sel[k]][wr_adr_i[k*ADR_WIDTH +: ADR_WIDTH]] <=
                    wr_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q      <= '0;
            rd_dat_q   <= '0;
            rd_vld_q   <= '0;
            conflict_q <= '0;
            for (int b = 0; b < BANK_NUM; b++) begin
                flag_q[b] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            rd_vld_q   <= rd_ena_i;
            conflict_q <= rd_ena_i & wr_ena_i;
            for (int k = 0; k < BANK_NUM; k++) begin
                if (rd_ena_i[k]) begin
                    rd_dat_q[k*DAT_WIDTH +: DAT_WIDTH] <=
                        flag_q[bank_sel[k]][rd_adr_i[k*ADR_WIDTH +: ADR_WIDTH]]
                        ? mem_q[bank_sel[k]][rd_adr_i[k*ADR_WIDTH +: ADR_WIDTH]]
                        : '0;
                end
                if (wr_go[k]) begin
                    flag_q[bank_sel[k]][wr_adr_i[k*ADR_WIDTH +: ADR_WIDTH]] <= 1'b1;
                end
            end
            // Later assignment wins: the clear overrides a same-cycle write.
            if (rotate_i) begin
                flag_q[clr_bank] <= '0;
            end
        end
    end

    assign rd_dat_o   = rd_dat_q;
    assign rd_vld_o   = rd_vld_q;
    assign conflict_o = conflict_q;
    assign rot_ptr_o  = ptr_q;
endmodule

// File: tb/tb_rec_buf_rot_nbank.sv
// tb/tb_rec_buf_rot_nbank.sv - randomized and directed checks of rec_buf_rot_nbank
module tb_rec_buf_rot_nbank;
    localparam int N = 3;
    localparam int W = 23;
    localparam int A = 6;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic           rotate;
    logic [N-1:0]   wr_ena, rd_ena;
    logic [N*A-1:0] wr_adr, rd_adr;
    logic [N*W-1:0] wr_dat, rd_dat;
    logic [N-1:0]   rd_vld, conflict;
    logic [1:0]     rot_ptr;

    logic        s_rot;
    logic [3:0]  s_wr_ena, s_rd_ena;
    logic [23:0] s_wr_adr, s_rd_adr;
    logic [31:0] s_wr_dat;
    logic [15:0] d2_dat;
    logic [1:0]  d2_vld, d2_conf;
    logic [0:0]  d2_ptr;
    logic [31:0] d4_dat;
    logic [3:0]  d4_vld, d4_conf;
    logic [1:0]  d4_ptr;

    rec_buf_rot_nbank dut (
        .clk(clk), .rstn(rstn), .rotate_i(rotate),
        .wr_ena_i(wr_ena), .wr_adr_i(wr_adr), .wr_dat_i(wr_dat),
        .rd_ena_i(rd_ena), .rd_adr_i(rd_adr),
        .rd_dat_o(rd_dat), .rd_vld_o(rd_vld), .conflict_o(conflict), .rot_ptr_o(rot_ptr)
    );

    rec_buf_rot_nbank #(.BANK_NUM(2), .DAT_WIDTH(8), .ADR_WIDTH(6), .DEPTH(64), .PTR_WIDTH(1)) dut2 (
        .clk(clk), .rstn(rstn), .rotate_i(s_rot),
        .wr_ena_i(s_wr_ena[1:0]), .wr_adr_i(s_wr_adr[11:0]), .wr_dat_i(s_wr_dat[15:0]),
        .rd_ena_i(s_rd_ena[1:0]), .rd_adr_i(s_rd_adr[11:0]),
        .rd_dat_o(d2_dat), .rd_vld_o(d2_vld), .conflict_o(d2_conf), .rot_ptr_o(d2_ptr)
    );

    rec_buf_rot_nbank #(.BANK_NUM(4), .DAT_WIDTH(8), .ADR_WIDTH(6), .DEPTH(64), .PTR_WIDTH(2)) dut4 (
        .clk(clk), .rstn(rstn), .rotate_i(s_rot),
        .wr_ena_i(s_wr_ena), .wr_adr_i(s_wr_adr), .wr_dat_i(s_wr_dat),
        .rd_ena_i(s_rd_ena), .rd_adr_i(s_rd_adr),
        .rd_dat_o(d4_dat), .rd_vld_o(d4_vld), .conflict_o(d4_conf), .rot_ptr_o(d4_ptr)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: banks as plain arrays, bank for stage k is (k - ptr) mod N.
    int unsigned m_mem  [N][64];
    bit          m_flag [N][64];
    int          m_ptr;
    logic [N*W-1:0] m_dat;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_dat = '0;
        for (int b = 0; b < N; b++)
            for (int a = 0; a < 64; a++) m_flag[b][a] = 1'b0;
    endtask

    task automatic idle();
        rotate = 1'b0; wr_ena = '0; rd_ena = '0;
        wr_adr = '0; rd_adr = '0; wr_dat = '0;
    endtask

    task automatic s_idle();
        s_rot = 1'b0; s_wr_ena = '0; s_rd_ena = '0;
        s_wr_adr = '0; s_rd_adr = '0; s_wr_dat = '0;
    endtask

    task automatic wr(input int k, input int a, input logic [W-1:0] d);
        wr_ena[k] = 1'b1;
        wr_adr[k*A +: A] = 6'(a);
        wr_dat[k*W +: W] = d;
    endtask

    task automatic rd(input int k, input int a);
        rd_ena[k] = 1'b1;
        rd_adr[k*A +: A] = 6'(a);
    endtask

    // Predict from current inputs, clock once, compare, then return to idle.
    task automatic step3();
        logic [N-1:0] ev, ec;
        int b, ra, wa;
        ev = '0; ec = '0;
        for (int k = 0; k < N; k++) begin
            b  = (k - m_ptr + N) % N;
            ra = int'(rd_adr[k*A +: A]);
            wa = int'(wr_adr[k*A +: A]);
            if (rd_ena[k]) begin
                ev[k] = 1'b1;
                m_dat[k*W +: W] = m_flag[b][ra] ? W'(m_mem[b][ra]) : '0;
                if (wr_ena[k]) ec[k] = 1'b1;
            end else if (wr_ena[k]) begin
                m_mem[b][wa]  = int'(wr_dat[k*W +: W]);
                m_flag[b][wa] = 1'b1;
            end
        end
        if (rotate) begin
            b = (N - 1 - m_ptr) % N;
            for (int a = 0; a < 64; a++) m_flag[b][a] = 1'b0;
            m_ptr = (m_ptr == N - 1) ? 0 : m_ptr + 1;
        end
        @(posedge clk); #1;
        chk("vld", rd_vld, ev);
        chk("conflict", conflict, ec);
        chk("dat", rd_dat, m_dat);
        chk("ptr", rot_ptr, m_ptr);
        idle();
    endtask

    task automatic sweep(input int n);
        logic [7:0] tok;
        logic [7:0] got;
        int st;
        tok = 8'hA0 + 8'(n);
        s_idle();
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        s_wr_ena[0] = 1'b1; s_wr_adr[5:0] = 6'd1; s_wr_dat[7:0] = tok;
        @(posedge clk); #1; s_idle();
        for (int s = 1; s <= n; s++) begin
            s_rot = 1'b1;
            @(posedge clk); #1; s_idle();
            st = s % n;
            s_rd_ena[st] = 1'b1; s_rd_adr[st*6 +: 6] = 6'd1;
            @(posedge clk); #1; s_idle();
            got = (n == 2) ? d2_dat[st*8 +: 8] : d4_dat[st*8 +: 8];
            chk($sformatf("sweep%0d_dat_s%0d", n, s), got, (s < n) ? tok : 8'h00);
            chk($sformatf("sweep%0d_vld_s%0d", n, s), (n == 2) ? d2_vld[st] : d4_vld[st], 1'b1);
        end
        chk($sformatf("sweep%0d_ptr", n), (n == 2) ? 2'(d2_ptr) : d4_ptr, 2'd0);
    endtask

    initial begin
        idle();
        s_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", rd_vld, 0);
        chk("rst_dat", rd_dat, 0);
        chk("rst_conflict", conflict, 0);
        chk("rst_ptr", rot_ptr, 0);
        rstn = 1'b1;

        // Token travels stage0 -> stage1 -> stage2, cleared on re-entry to stage0.
        wr(0, 5, 23'h12345); step3();
        rotate = 1'b1; step3();
        rd(1, 5); step3();
        chk("t1_dat", rd_dat[W +: W], 23'h12345);
        chk("t1_vld", rd_vld[1], 1'b1);
        chk("t1_ptr", rot_ptr, 2'd1);
        rotate = 1'b1; step3();
        rd(2, 5); step3();
        chk("t2_dat_s2", rd_dat[2*W +: W], 23'h12345);
        rotate = 1'b1; step3();
        chk("t2_ptr_wrap", rot_ptr, 2'd0);
        rd(0, 5); step3();
        chk("t2_dat_s0", rd_dat[0 +: W], 23'h0);
        chk("t2_vld_s0", rd_vld[0], 1'b1);

        // Same-stage collision drops the write.
        rd(0, 3); wr(0, 3, 23'h7F); step3();
        chk("t3_conflict", conflict[0], 1'b1);
        step3();
        chk("t3_conflict_clr", conflict[0], 1'b0);
        rd(0, 3); step3();
        chk("t3_dat", rd_dat[0 +: W], 23'h0);

        // Read during rotate sees pre-clear content.
        wr(0, 9, 23'h55); step3();
        rotate = 1'b1; step3();
        rotate = 1'b1; step3();
        rd(2, 9); rotate = 1'b1; step3();
        chk("t4_dat", rd_dat[2*W +: W], 23'h55);
        chk("t4_vld", rd_vld[2], 1'b1);
        rd(0, 9); step3();
        chk("t4_cleared", rd_dat[0 +: W], 23'h0);

        // Burst write interrupted by asynchronous reset.
        for (int i = 0; i < 64; i++) begin
            if (i == 32) begin
                idle();
                rstn = 1'b0;
                #1;
                chk("t5_vld", rd_vld, 0);
                chk("t5_dat", rd_dat, 0);
                chk("t5_conflict", conflict, 0);
                chk("t5_ptr", rot_ptr, 0);
                model_reset();
                @(posedge clk); #1;
                rstn = 1'b1;
            end
            wr(0, i, 23'(i * 3 + 1));
            if (i == 20) rotate = 1'b1;
            if (i == 31) rd(2, 9);
            step3();
        end
        for (int i = 0; i < 32; i++) begin
            rd(0, i); rd(1, i); rd(2, i); step3();
            chk("t5_post", rd_dat, 0);
        end

        for (int c = 0; c < 2000; c++) begin
            rotate = ($urandom_range(3) == 0);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(1) == 1) wr(k, int'($urandom_range(7)), W'($urandom));
                if ($urandom_range(2) == 0) rd(k, int'($urandom_range(7)));
            end
            step3();
        end

        sweep(2);
        sweep(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
